// File: rtl/regbank_debug_arbiter.sv
// Shares regbank read port A and the write port between the pipeline and a
// debug interface: stall, settle, one debug access, operand refresh, ack.
`timescale 1ns/1ps
module regbank_debug_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned RD_LATENCY    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [3:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic        dbg_busy,
  output logic        pipe_stall,
  input  logic [3:0]  pipe_addr_a,
  input  logic [3:0]  pipe_addr_b,
  input  logic        pipe_hold_in,
  input  logic        pipe_clear_in,
  input  logic [3:0]  wb_addr_d,
  input  logic [31:0] wb_data_d,
  input  logic        wb_we,
  output logic [3:0]  rb_addr_a,
  output logic [3:0]  rb_addr_b,
  output logic        rb_hold,
  output logic        rb_clear,
  output logic [3:0]  rb_addr_d,
  output logic [31:0] rb_data_d,
  output logic        rb_we,
  input  logic [31:0] rb_data_a
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST     = CNT_W'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE, SETTLE, RD, RD_WAIT, WR, RESTORE, DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             req_we;
  logic [3:0]       req_addr;
  logic [31:0]      req_wdata;

  // Sequencer: state, counter, captured request and all dbg/pipe outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      pipe_stall <= 1'b0;
      dbg_ack    <= 1'b0;
      dbg_busy   <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      dbg_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (dbg_req) begin
            req_we     <= dbg_we;
            req_addr   <= dbg_addr;
            req_wdata  <= dbg_wdata;
            cnt        <= '0;
            pipe_stall <= 1'b1;
            dbg_busy   <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= req_we ? WR : RD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RD: begin
          cnt   <= '0;
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (cnt == RD_LAST) begin
            dbg_rdata <= rb_data_a;
            cnt       <= '0;
            state     <= RESTORE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WR: begin
          // WB owns the write port whenever it shows up; retry next cycle.
          if (!wb_we) begin
            cnt   <= '0;
            state <= RESTORE;
          end
        end
        RESTORE: begin
          if (cnt == RD_LAST) begin
            cnt        <= '0;
            pipe_stall <= 1'b0;
            dbg_ack    <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          dbg_busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          pipe_stall <= 1'b0;
          dbg_busy   <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // Regbank port steering decoded from state.
  always_comb begin
    rb_addr_a = pipe_addr_a;
    rb_addr_b = pipe_addr_b;
    rb_hold   = 1'b1;
    rb_clear  = 1'b0;
    rb_addr_d = wb_addr_d;
    rb_data_d = wb_data_d;
    rb_we     = wb_we;
    case (state)
      IDLE: begin
        rb_hold  = pipe_hold_in;
        rb_clear = pipe_clear_in;
      end
      RD, RD_WAIT: begin
        rb_addr_a = req_addr;
        rb_hold   = 1'b0;
      end
      WR: begin
        if (!wb_we) begin
          rb_we     = 1'b1;
          rb_addr_d = req_addr;
          rb_data_d = req_wdata;
        end
      end
      RESTORE: rb_hold = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regbank_debug_arbiter.sv
// Bench for regbank_debug_arbiter: regbank model, ack scoreboard and
// directed debug read/write scenarios.
`timescale 1ns/1ps
module tb_regbank_debug_arbiter;

  localparam int unsigned SETTLE = 2;
  localparam int unsigned RDL    = 1;
  localparam int LAT_RD = SETTLE + 2 * RDL + 2;
  localparam int LAT_WR = SETTLE + RDL + 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        dbg_req, dbg_we;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack, dbg_busy, pipe_stall;
  logic [31:0] dbg_rdata;
  logic [3:0]  pipe_addr_a, pipe_addr_b;
  logic        pipe_hold_in, pipe_clear_in;
  logic [3:0]  wb_addr_d;
  logic [31:0] wb_data_d;
  logic        wb_we;
  logic [3:0]  rb_addr_a, rb_addr_b, rb_addr_d;
  logic        rb_hold, rb_clear, rb_we;
  logic [31:0] rb_data_d;
  logic [31:0] data_a_m, data_b_m;
  logic [31:0] regs [16];

  typedef struct {
    logic        we;
    logic [31:0] rdata;
    int          lat;
    int          pulses;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  regbank_debug_arbiter #(.SETTLE_CYCLES(SETTLE), .RD_LATENCY(RDL)) dut (
    .clk(clk), .reset(reset),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_busy(dbg_busy),
    .pipe_stall(pipe_stall),
    .pipe_addr_a(pipe_addr_a), .pipe_addr_b(pipe_addr_b),
    .pipe_hold_in(pipe_hold_in), .pipe_clear_in(pipe_clear_in),
    .wb_addr_d(wb_addr_d), .wb_data_d(wb_data_d), .wb_we(wb_we),
    .rb_addr_a(rb_addr_a), .rb_addr_b(rb_addr_b),
    .rb_hold(rb_hold), .rb_clear(rb_clear),
    .rb_addr_d(rb_addr_d), .rb_data_d(rb_data_d), .rb_we(rb_we),
    .rb_data_a(data_a_m)
  );

  // Regbank model: r0 hardwired to zero, registered read ports with hold/clear.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= 32'h100 + 32'(i);
      regs[0] <= 32'h0;
      regs[7] <= 32'hDEADBEEF;
    end else if (rb_we && rb_addr_d != 4'd0) begin
      regs[rb_addr_d] <= rb_data_d;
    end
    if (rb_clear) begin
      data_a_m <= 32'h0;
      data_b_m <= 32'h0;
    end else if (!rb_hold) begin
      data_a_m <= regs[rb_addr_a];
      data_b_m <= regs[rb_addr_b];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ack monitor: latency from busy rise, write-port pulses while busy, rdata.
  int   mon_cyc = 0;
  int   mon_pulses = 0;
  logic busy_q = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      mon_cyc = 0;
      mon_pulses = 0;
      busy_q = 1'b0;
    end else begin
      if (dbg_busy && !busy_q) begin
        mon_cyc = 1;
        mon_pulses = 0;
      end else if (dbg_busy) begin
        mon_cyc++;
      end
      if (dbg_busy && rb_we) mon_pulses++;
      if (dbg_ack) begin
        check("ack_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          if (!e.we) check("rdata", dbg_rdata, e.rdata);
          check("ack_latency", 32'(mon_cyc), 32'(e.lat));
          check("wr_pulses", 32'(mon_pulses), 32'(e.pulses));
          check("ack_stall_low", 32'(pipe_stall), 32'd0);
        end
      end
      busy_q = dbg_busy;
    end
  end

  // One debug transaction, called and returning at posedge+1 of an IDLE cycle.
  task automatic do_op(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input int lat, input int pulses,
                       input bit wb_acc, input int wb_force_n, input bit drop_early);
    int n;
    bit done;
    exp_t e;
    e.we = we; e.rdata = exp_rd; e.lat = lat; e.pulses = pulses;
    sb.push_back(e);
    check("idle_stall", 32'(pipe_stall), 32'd0);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    if (wb_acc) begin
      wb_we = 1'b1; wb_addr_d = 4'd2; wb_data_d = 32'h0000_2222;
    end
    n = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      step();
      n++;
      wb_we = (n == wb_force_n);
      wb_addr_d = 4'd9;
      wb_data_d = 32'h0000_9999;
      if (n == 1) begin
        check("stall_after_accept", 32'(pipe_stall), 32'd1);
        check("busy_after_accept", 32'(dbg_busy), 32'd1);
        if (drop_early) dbg_req = 1'b0;
      end
      if (!we && n == SETTLE + 1) begin
        check("rd_addr_a", 32'(rb_addr_a), 32'(addr));
        check("rd_hold", 32'(rb_hold), 32'd0);
      end
      if (dbg_ack) begin
        done = 1'b1;
        dbg_req = 1'b0;
      end
    end
    if (!done) begin
      check("ack_timeout", 32'd0, 32'd1);
      dbg_req = 1'b0;
    end
    wb_we = 1'b0;
    step();
    check("busy_after_done", 32'(dbg_busy), 32'd0);
    if (!we) check("rdata_hold", dbg_rdata, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    pipe_addr_a = '0; pipe_addr_b = '0; pipe_hold_in = 1'b0; pipe_clear_in = 1'b0;
    wb_addr_d = '0; wb_data_d = '0; wb_we = 1'b0;
    repeat (3) step();
    check("rst_stall", 32'(pipe_stall), 32'd0);
    check("rst_ack", 32'(dbg_ack), 32'd0);
    check("rst_busy", 32'(dbg_busy), 32'd0);
    check("rst_rdata", dbg_rdata, 32'd0);
    reset = 1'b0;
    step();

    // Idle passthrough
    pipe_addr_a = 4'd3; pipe_addr_b = 4'd6; pipe_hold_in = 1'b1; pipe_clear_in = 1'b1;
    wb_we = 1'b1; wb_addr_d = 4'd5; wb_data_d = 32'h1234;
    @(negedge clk);
    check("pt_addr_a", 32'(rb_addr_a), 32'd3);
    check("pt_addr_b", 32'(rb_addr_b), 32'd6);
    check("pt_hold", 32'(rb_hold), 32'd1);
    check("pt_clear", 32'(rb_clear), 32'd1);
    check("pt_we", 32'(rb_we), 32'd1);
    check("pt_addr_d", 32'(rb_addr_d), 32'd5);
    check("pt_data_d", rb_data_d, 32'h1234);
    check("pt_stall", 32'(pipe_stall), 32'd0);
    check("pt_ack", 32'(dbg_ack), 32'd0);
    check("pt_rdata", dbg_rdata, 32'd0);
    step();
    wb_we = 1'b0; pipe_hold_in = 1'b0; pipe_clear_in = 1'b0;
    step();
    check("pt_wb_landed", regs[5], 32'h1234);

    // Debug read of preloaded r7
    do_op(1'b0, 4'd7, 32'h0, 32'hDEADBEEF, LAT_RD, 0, 1'b0, 0, 1'b0);

    // Debug write r4 with operands pointing at r4: refresh must see new value
    pipe_addr_a = 4'd4; pipe_addr_b = 4'd4;
    do_op(1'b1, 4'd4, 32'hCAFEF00D, 32'h0, LAT_WR, 1, 1'b0, 0, 1'b0);
    check("wr_reg4", regs[4], 32'hCAFEF00D);
    check("refresh_a", data_a_m, 32'hCAFEF00D);
    check("refresh_b", data_b_m, 32'hCAFEF00D);
    pipe_addr_a = 4'd3; pipe_addr_b = 4'd6;

    // WB in acceptance cycle and WB colliding with the first WR cycle
    do_op(1'b1, 4'd6, 32'h0000_6666, 32'h0, LAT_WR + 1, 2, 1'b1, SETTLE + 1, 1'b0);
    check("wb_acc_landed", regs[2], 32'h0000_2222);
    check("wb_wr_landed", regs[9], 32'h0000_9999);
    check("dbg_wr_landed", regs[6], 32'h0000_6666);

    // r0 read and write
    do_op(1'b0, 4'd0, 32'h0, 32'h0, LAT_RD, 0, 1'b0, 0, 1'b0);
    do_op(1'b1, 4'd0, 32'hFFFFFFFF, 32'h0, LAT_WR, 1, 1'b0, 0, 1'b0);
    check("r0_zero", regs[0], 32'h0);
    do_op(1'b0, 4'd0, 32'h0, 32'h0, LAT_RD, 0, 1'b0, 0, 1'b0);

    // Request dropped right after acceptance still completes
    do_op(1'b1, 4'd3, 32'h0000_3333, 32'h0, LAT_WR, 1, 1'b0, 0, 1'b1);
    check("early_drop_wr", regs[3], 32'h0000_3333);
    do_op(1'b0, 4'd3, 32'h0, 32'h0000_3333, LAT_RD, 0, 1'b0, 0, 1'b1);

    // Reset while in RD_WAIT drops the request without ack
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 4'd7;
    for (int i = 0; i < SETTLE + 2; i++) step();
    check("mid_busy", 32'(dbg_busy), 32'd1);
    reset = 1'b1;
    dbg_req = 1'b0;
    step();
    reset = 1'b0;
    check("rst_mid_stall", 32'(pipe_stall), 32'd0);
    check("rst_mid_busy", 32'(dbg_busy), 32'd0);
    check("rst_mid_ack", 32'(dbg_ack), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      check("rst_no_ack", 32'(dbg_ack), 32'd0);
    end
    do_op(1'b0, 4'd7, 32'h0, 32'hDEADBEEF, LAT_RD, 0, 1'b0, 0, 1'b0);

    repeat (3) step();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regbank_debug_arbiter.md
Name: regbank_debug_arbiter

Overview:
Shares the CPU register bank's read port A and write port between the pipeline and an external debug/monitor interface.
In idle it is a transparent pass-through for pipeline REG-stage and WB-stage signals.
On a debug request it freezes the pipeline, waits for it to settle, then performs a single register read or write. It then re-reads the pipeline's operand addresses so the held operands are current, and releases the pipeline with a one-cycle acknowledge.

Parameters:
SETTLE_CYCLES, 2, cycles spent in SETTLE after pipe_stall rises, before any regbank access (1..15).
RD_LATENCY, 1, regbank read latency in cycles, from address to valid data_a/data_b (1..3).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
dbg_req  in  1  debug request; level, held until dbg_ack
dbg_we  in  1  1 = write, 0 = read; sampled at acceptance
dbg_addr  in  4  register index; sampled at acceptance
dbg_wdata  in  32  write data; sampled at acceptance
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  32  read result; valid from the dbg_ack cycle until the next acceptance
dbg_busy  out  1  high in every non-IDLE state
pipe_stall  out  1  freeze request to pipeline
pipe_addr_a, pipe_addr_b  in  4 each  REG-stage operand addresses
pipe_hold_in, pipe_clear_in  in  1 each  REG-stage hold/clear from pipeline
wb_addr_d  in  4  WB destination
wb_data_d  in  32  WB data
wb_we  in  1  WB write enable
rb_addr_a, rb_addr_b  out  4 each  to regbank
rb_hold, rb_clear  out  1 each  to regbank
rb_addr_d  out  4  to regbank
rb_data_d  out  32  to regbank
rb_we  out  1  to regbank
rb_data_a  in  32  regbank port A output

Behaviour:
- FSM states: IDLE, SETTLE, RD, RD_WAIT, WR, RESTORE, DONE. State, counter and captured request are registered. rb_* outputs are combinational decodes of the state.
- Reset:
  - state=IDLE, counter=0, pipe_stall=0, dbg_ack=0, dbg_busy=0, dbg_rdata=0.
  - Any in-flight request is dropped with no ack; the requester must re-present it.
  - Reset has priority over all other inputs.
- IDLE:
  - rb_addr_a/b=pipe_addr_a/b, rb_hold=pipe_hold_in, rb_clear=pipe_clear_in.
  - rb_addr_d/rb_data_d/rb_we = wb_*.
  - If dbg_req=1: capture dbg_we/addr/wdata, set pipe_stall=1 and counter=0, go to SETTLE. The WB write presented in the acceptance cycle passes through unchanged.
- Non-IDLE states:
  - pipe_stall=1 in every non-IDLE state except DONE.
  - rb_clear=0. rb_addr_b=pipe_addr_b. rb_hold=1 except in RD, RD_WAIT and RESTORE.
  - The pipeline drops wb_we while stalled. The arbiter still honours wb_we if it is seen: WB has write-port priority.
- SETTLE:
  - Hold for SETTLE_CYCLES cycles (counter, then clear counter).
  - Then go to RD if the captured we=0, or WR if we=1.
- RD:
  - rb_addr_a=captured addr, rb_hold=0, for 1 cycle; go to RD_WAIT.
- RD_WAIT:
  - rb_addr_a=captured addr, rb_hold=0, for RD_LATENCY cycles.
  - On the last cycle, register dbg_rdata<=rb_data_a. Reading r0 returns 0 via the regbank.
  - Go to RESTORE.
- WR:
  - If wb_we=1 this cycle, the WB signals drive the write port and the arbiter stays in WR.
  - Otherwise rb_we=1, rb_addr_d=captured addr, rb_data_d=captured wdata for exactly 1 cycle, then go to RESTORE.
  - A write to r0 is issued normally; the regbank discards it; ack as usual.
- RESTORE:
  - rb_addr_a=pipe_addr_a, rb_addr_b=pipe_addr_b, rb_hold=0, for RD_LATENCY cycles. This refreshes the operands, including one just written by debug.
  - Go to DONE.
- DONE:
  - dbg_ack=1, rb_hold=1, pipe_stall=0.
  - Next state is IDLE unconditionally. A dbg_req still high in that IDLE cycle is treated as a new request.
- Latency from the acceptance edge to dbg_ack high:
  - Read: SETTLE_CYCLES + 2*RD_LATENCY + 2 cycles.
  - Write: SETTLE_CYCLES + RD_LATENCY + 2 cycles, plus 1 per cycle WB occupies the write port in WR.
- dbg_req dropping before dbg_ack does not abort the operation; the ack is still produced.
- pipe_hold_in and pipe_clear_in are ignored outside IDLE.

Test Plan:
- Reset, then idle passthrough: pipe_addr_a=3, wb_we=1, wb_addr_d=5, wb_data_d=0x1234 -> rb_* mirror the inputs the same cycle; pipe_stall=0, dbg_ack=0, dbg_rdata=0.
- Debug read of r7 preloaded with 0xDEADBEEF (defaults) -> pipe_stall high from the cycle after acceptance; dbg_ack in cycle 6 after acceptance; dbg_rdata=0xDEADBEEF; pipe_stall=0 in the ack cycle.
- Debug write r4=0xCAFEF00D with pipe_addr_a=4 -> single rb_we pulse; ack in cycle 5; regbank data_a=0xCAFEF00D in the DONE cycle.
- wb_we=1 to r2 in the acceptance cycle, and wb_we forced high on the first WR cycle -> both WB writes land; the debug write is delayed 1 cycle; ack in cycle 6.
- Read r0 -> dbg_rdata=0. Write r0=0xFFFFFFFF -> regbank r0 stays 0; both acked.
- Assert reset in RD_WAIT -> next cycle pipe_stall=0, dbg_busy=0, no ack. A re-issued request completes normally.
